// File: rtl/mux_pkg.sv
// Shared definitions for the 8-lane mux/demux pair.
package mux_pkg;
  localparam int LANES = 8;
  localparam int SEL_W = 3;

  typedef logic [SEL_W-1:0] sel_t;

  // Pointer value after reset: search starts at lane 0.
  localparam sel_t LAST_RESET = sel_t'(LANES - 1);
endpackage

// File: rtl/rr_mux_8x1_if.sv
// Lane-side and output-side bus of the 8x1 round-robin mux.
//
// Handshake: a word moves across a valid/ready pair on a rising clk edge where
// valid and ready are both 1. A source holds valid and data stable until that
// edge. ready may depend combinationally on valid; valid must never depend on
// ready.
interface rr_mux_8x1_if #(parameter int DATA_W = 8);
  import mux_pkg::*;

  logic [LANES-1:0]        in_valid;
  logic [LANES*DATA_W-1:0] in_data;
  logic [LANES-1:0]        in_ready;
  logic                    out_valid;
  logic [DATA_W-1:0]       out_data;
  sel_t                    out_sel;
  logic                    out_ready;

  // Producer/consumer side (drives lanes, accepts output).
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  // Mux side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/rr_arbiter_8.sv
// Combinational round-robin arbiter: first requester after 'last', wrapping.
module rr_arbiter_8
  import mux_pkg::*;
(
  input  logic [LANES-1:0] req,
  input  sel_t             last,
  input  logic             en,
  output logic [LANES-1:0] gnt,
  output sel_t             gnt_idx,
  output logic             gnt_vld
);

  sel_t w_cand;

  // Search last+1 .. last+8 (mod 8); the final candidate is 'last' itself,
  // so a lone requester that won last time is granted again.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= LANES; k++) begin
      w_cand = last + sel_t'(k);
      if (en && !gnt_vld && req[w_cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = w_cand;
      end
    end
    gnt[gnt_idx] = gnt_vld;
  end

endmodule

// File: rtl/rr_mux_8x1.sv
// 8-to-1 round-robin valid/ready mux with a single registered output stage.
// out_sel carries the source lane so a downstream demux can route back.
module rr_mux_8x1
  import mux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  rr_mux_8x1_if.slave  bus,
  output sel_t         o_dbg_last
);

  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  sel_t              r_out_sel;
  sel_t              r_last;

  logic              w_load;
  logic              w_arb_en;
  logic [LANES-1:0]  w_gnt;
  sel_t              w_gnt_idx;
  logic              w_gnt_vld;
  logic [DATA_W-1:0] w_lane_data;

  // Register can take a word when empty or being drained this cycle;
  // reset blocks every lane so nothing is accepted while it is asserted.
  assign w_load   = ~r_out_valid | bus.out_ready;
  assign w_arb_en = w_load & ~rst;

  rr_arbiter_8 u_arb (
    .req     (bus.in_valid),
    .last    (r_last),
    .en      (w_arb_en),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx),
    .gnt_vld (w_gnt_vld)
  );

  assign bus.in_ready = w_gnt;
  assign w_lane_data  = bus.in_data[int'(w_gnt_idx)*DATA_W +: DATA_W];

  // Output stage: load on transfer, clear valid on plain drain, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_last      <= LAST_RESET;
    end else if (w_gnt_vld) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_lane_data;
      r_out_sel   <= w_gnt_idx;
      r_last      <= w_gnt_idx;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_sel   = r_out_sel;
  assign o_dbg_last    = r_last;

endmodule
